// File: rtl/avm_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : avm_cmd_master
// Purpose  : FIFO-buffered Avalon-MM initiator for the VGA register/tile-RAM
//            slave; optional waitrequest timeout via AVM_WAIT_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module avm_cmd_master #(
  parameter int DEPTH        = 8,
  parameter int READ_LATENCY = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [11:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [3:0]  cmd_byte_en,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        err,
  output logic        AVL_CS,
  output logic        AVL_READ,
  output logic        AVL_WRITE,
  output logic [11:0] AVL_ADDR,
  output logic [3:0]  AVL_BYTE_EN,
  output logic [31:0] AVL_WRITEDATA,
  input  logic [31:0] AVL_READDATA,
  input  logic        AVL_WAITREQUEST
);

  localparam int              c_AW       = $clog2(DEPTH);
  localparam int              c_CW       = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH    = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);
  localparam logic [3:0]      c_LAT_INIT = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_RD_WAIT = 2'd2} state_t;

  logic [48:0]      r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [c_CW-1:0]  r_count;
  state_t           r_state;
  logic             r_cs, r_rd, r_wr;
  logic [11:0]      r_addr;
  logic [3:0]       r_be;
  logic [31:0]      r_wdata;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_data;
  logic [3:0]       r_lat;

  logic             w_push, w_pop, w_accept, w_drop, w_more, w_load;
  logic [c_AW-1:0]  w_next_ptr;
  logic [48:0]      w_ld;

  assign cmd_ready  = (r_count != c_DEPTH);
  assign w_push     = cmd_valid && cmd_ready;
  assign w_accept   = (r_state == S_ISSUE) && !AVL_WAITREQUEST;
  assign w_pop      = w_accept || w_drop;
  assign w_more     = (r_count > c_ONE);
  assign w_next_ptr = r_rd_ptr + c_AW'(1);
  // In ISSUE the head is being popped this cycle, so the follower is next.
  assign w_ld       = (r_state == S_ISSUE) ? r_mem[w_next_ptr] : r_mem[r_rd_ptr];
  assign w_load     = ((r_state == S_IDLE) && (r_count != '0)) ||
                      (w_accept && r_wr && w_more) ||
                      ((r_state == S_RD_WAIT) && (r_lat == 4'd0) && (r_count != '0));

`ifdef AVM_WAIT_TIMEOUT_EN
  localparam int              c_TW      = $clog2(TIMEOUT + 1);
  localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT - 1);
  logic [c_TW-1:0] r_to_cnt;
  logic            r_err;
  assign w_drop = (r_state == S_ISSUE) && AVL_WAITREQUEST && (r_to_cnt == c_TO_LAST);
  assign err    = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_drop = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {cmd_write, cmd_addr, cmd_data, cmd_byte_en};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= w_next_ptr;
      if (w_push && !w_pop)      r_count <= r_count + c_ONE;
      else if (!w_push && w_pop) r_count <= r_count - c_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cs        <= 1'b0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_lat       <= '0;
`ifdef AVM_WAIT_TIMEOUT_EN
      r_to_cnt    <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_load) begin
        r_cs    <= 1'b1;
        r_wr    <= w_ld[48];
        r_rd    <= ~w_ld[48];
        r_addr  <= w_ld[47:36];
        r_wdata <= w_ld[35:4];
        r_be    <= w_ld[3:0];
        r_state <= S_ISSUE;
      end
`ifdef AVM_WAIT_TIMEOUT_EN
      if ((r_state == S_ISSUE) && AVL_WAITREQUEST && !w_drop) r_to_cnt <= r_to_cnt + c_TW'(1);
      else                                                     r_to_cnt <= '0;
`endif
      case (r_state)
        S_IDLE: ;
        S_ISSUE: begin
          if (w_accept) begin
            if (!r_wr) begin
              {r_cs, r_rd, r_wr} <= 3'b000;
              r_lat   <= c_LAT_INIT;
              r_state <= S_RD_WAIT;
            end else if (!w_more) begin
              {r_cs, r_rd, r_wr} <= 3'b000;
              r_state <= S_IDLE;
            end
          end
`ifdef AVM_WAIT_TIMEOUT_EN
          else if (w_drop) begin
            {r_cs, r_rd, r_wr} <= 3'b000;
            r_err   <= 1'b1;
            r_state <= S_IDLE;
            if (r_rd) begin
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= 32'hDEADBEEF;
            end
          end
`endif
        end
        S_RD_WAIT: begin
          if (r_lat == 4'd0) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= AVL_READDATA;
            if (r_count == '0) r_state <= S_IDLE;
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = (r_count != '0) || (r_state != S_IDLE);
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign AVL_CS        = r_cs;
  assign AVL_READ      = r_rd;
  assign AVL_WRITE     = r_wr;
  assign AVL_ADDR      = r_addr;
  assign AVL_BYTE_EN   = r_be;
  assign AVL_WRITEDATA = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_avm_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_avm_cmd_master
// Purpose  : Directed self-checking bench for avm_cmd_master.
// Revision : 1.0  initial release
// ============================================================================
module tb_avm_cmd_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_byte_en;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy, err;
  logic        AVL_CS, AVL_READ, AVL_WRITE;
  logic [11:0] AVL_ADDR;
  logic [3:0]  AVL_BYTE_EN;
  logic [31:0] AVL_WRITEDATA, AVL_READDATA;
  logic        AVL_WAITREQUEST;

  int n_chk  = 0;
  int n_fail = 0;

  avm_cmd_master #(.DEPTH(8), .READ_LATENCY(2), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_byte_en(cmd_byte_en),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .err(err),
    .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA(AVL_READDATA), .AVL_WAITREQUEST(AVL_WAITREQUEST)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_data = '0; cmd_byte_en = '0; AVL_WAITREQUEST = 1'b0;
    AVL_READDATA = 32'hBAD0BAD0;
    tick(); tick();
    chk("rst_cs", 32'(AVL_CS), 0);
    chk("rst_rdwr", 32'({AVL_READ, AVL_WRITE}), 0);
    chk("rst_addr", 32'(AVL_ADDR), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_rsp", 32'(rsp_valid), 0);
    chk("rst_rspdata", rsp_data, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    reset = 1'b0;

    // Single write
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h800;
    cmd_data = 32'h00141400; cmd_byte_en = 4'hF;
    tick();
    cmd_valid = 1'b0;
    chk("w1_cs_pre", 32'(AVL_CS), 0);
    chk("w1_busy_pre", 32'(busy), 1);
    tick();
    chk("w1_cswr", 32'({AVL_CS, AVL_WRITE, AVL_READ}), 32'b110);
    chk("w1_addr", 32'(AVL_ADDR), 32'h800);
    chk("w1_data", AVL_WRITEDATA, 32'h00141400);
    chk("w1_be", 32'(AVL_BYTE_EN), 32'hF);
    tick();
    chk("w1_cs_post", 32'(AVL_CS), 0);
    chk("w1_busy_post", 32'(busy), 0);

    // Four back-to-back writes
    cmd_valid = 1'b1; cmd_addr = 12'h002; cmd_data = 32'h2; cmd_byte_en = 4'h3;
    tick();
    chk("b2b_idle", 32'(AVL_CS), 0);
    cmd_addr = 12'h003; cmd_data = 32'h3;
    tick();
    chk("b2b_0", 32'({AVL_CS, AVL_WRITE, AVL_ADDR}), {18'd0, 2'b11, 12'h002});
    chk("b2b_0_be", 32'(AVL_BYTE_EN), 32'h3);
    cmd_addr = 12'h017; cmd_data = 32'h17;
    tick();
    chk("b2b_1", 32'({AVL_CS, AVL_WRITE, AVL_ADDR}), {18'd0, 2'b11, 12'h003});
    cmd_addr = 12'h018; cmd_data = 32'h18;
    tick();
    chk("b2b_2", 32'({AVL_CS, AVL_WRITE, AVL_ADDR}), {18'd0, 2'b11, 12'h017});
    cmd_valid = 1'b0;
    tick();
    chk("b2b_3", 32'({AVL_CS, AVL_WRITE, AVL_ADDR}), {18'd0, 2'b11, 12'h018});
    chk("b2b_3_data", AVL_WRITEDATA, 32'h18);
    tick();
    chk("b2b_end_cs", 32'(AVL_CS), 0);
    chk("b2b_end_busy", 32'(busy), 0);

    // Read with 3 stall cycles, latency 2
    AVL_WAITREQUEST = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h017; cmd_byte_en = 4'hC;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rd_issue", 32'({AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR}), {17'd0, 3'b110, 12'h017});
    chk("rd_be", 32'(AVL_BYTE_EN), 32'hC);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd_stall", 32'({AVL_CS, AVL_READ, AVL_ADDR}), {18'd0, 2'b11, 12'h017});
    end
    AVL_WAITREQUEST = 1'b0;
    tick();
    chk("rd_acc_cs", 32'({AVL_CS, AVL_READ}), 0);
    chk("rd_acc_busy", 32'(busy), 1);
    chk("rd_acc_rsp", 32'(rsp_valid), 0);
    tick();
    chk("rd_lat1_rsp", 32'(rsp_valid), 0);
    AVL_READDATA = 32'h00003C6C;
    tick();
    AVL_READDATA = 32'hBAD0BAD0;
    chk("rd_rsp_valid", 32'(rsp_valid), 1);
    chk("rd_rsp_data", rsp_data, 32'h00003C6C);
    tick();
    chk("rd_rsp_pulse", 32'(rsp_valid), 0);
    chk("rd_rsp_hold", rsp_data, 32'h00003C6C);
    chk("rd_busy_end", 32'(busy), 0);

    // Fill FIFO while stalled, then drain
    AVL_WAITREQUEST = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_byte_en = 4'hF;
    for (int i = 0; i < 10; i++) begin
      cmd_addr = 12'h100 + 12'(i);
      cmd_data = 32'hA000 + 32'(i);
      tick();
      chk("full_ready", 32'(cmd_ready), (i < 7) ? 32'd1 : 32'd0);
    end
    cmd_valid = 1'b0;
    chk("full_head", 32'({AVL_CS, AVL_ADDR}), {19'd0, 1'b1, 12'h100});
    AVL_WAITREQUEST = 1'b0;
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("drain_addr", 32'({AVL_CS, AVL_WRITE, AVL_ADDR}), {18'd0, 2'b11, 12'h100 + 12'(k)});
      chk("drain_data", AVL_WRITEDATA, 32'hA000 + 32'(k));
    end
    chk("drain_ready", 32'(cmd_ready), 1);
    tick();
    chk("drain_cs_end", 32'(AVL_CS), 0);
    chk("drain_busy_end", 32'(busy), 0);

    // Reset while reads are queued and one is issuing
    AVL_WAITREQUEST = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_addr = 12'h200 + 12'(i);
      tick();
    end
    cmd_valid = 1'b0;
    chk("mrst_pre_cs", 32'({AVL_CS, AVL_READ}), 32'b11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    AVL_WAITREQUEST = 1'b0;
    chk("mrst_cs", 32'({AVL_CS, AVL_READ, AVL_WRITE}), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_ready", 32'(cmd_ready), 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mrst_no_rsp", 32'({rsp_valid, AVL_CS}), 0);
    end

`ifdef AVM_WAIT_TIMEOUT_EN
    // Timeout on a stuck read, then a queued write completes
    AVL_WAITREQUEST = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h020;
    tick();
    cmd_write = 1'b1; cmd_addr = 12'h021; cmd_data = 32'h21;
    tick();
    cmd_valid = 1'b0;
    chk("to_issue", 32'({AVL_CS, AVL_READ, AVL_ADDR}), {18'd0, 2'b11, 12'h020});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_stall", 32'({AVL_CS, AVL_READ, err}), 32'b110);
    end
    tick();
    AVL_WAITREQUEST = 1'b0;
    chk("to_drop_cs", 32'(AVL_CS), 0);
    chk("to_err", 32'(err), 1);
    chk("to_rsp_valid", 32'(rsp_valid), 1);
    chk("to_rsp_data", rsp_data, 32'hDEADBEEF);
    tick();
    chk("to_next_wr", 32'({AVL_CS, AVL_WRITE, AVL_ADDR}), {18'd0, 2'b11, 12'h021});
    chk("to_rsp_pulse", 32'(rsp_valid), 0);
    tick();
    chk("to_wr_done", 32'({AVL_CS, busy}), 0);
    chk("to_err_sticky", 32'(err), 1);
`else
    chk("err_tied", 32'(err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
